fibre_a_responder: RTL and testbench

FIBRE_A_RESPONDER -- requirements
Module: fibre_a_responder

---
 rtl/fibre_a_responder.sv | 140 ++++++++++++++
 tb/tb_fibre_a_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fibre_a_responder.sv
// Spike-word store for the fibre_a port: streamed burst loads plus a fixed two-cycle read pipeline.
// Tracks which words were ever written and flags reads of stale storage.
module fibre_a_responder #(
    parameter int TIMESTEPS  = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fibre_a_read_en,
    input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
    output logic [TIMESTEPS-1:0]  fibre_a_data,
    output logic                  fibre_a_valid,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  load_valid,
    input  logic [TIMESTEPS-1:0]  load_data,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  rd_err
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    // state   | meaning
    // IDLE    | no burst active, load_valid ignored
    // LOADING | accepting burst words, load_ready high
    typedef enum logic {IDLE, LOADING} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic                  done_q, done_d;
    logic [DEPTH-1:0]      written_q, written_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_hit_q, s1_hit_d;
    logic [TIMESTEPS-1:0]  s1_data_q, s1_data_d;
    logic                  valid_q, valid_d;
    logic [TIMESTEPS-1:0]  data_q, data_d;
    logic                  err_q, err_d;

    logic [TIMESTEPS-1:0]  mem [DEPTH];
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  last_word;
    logic                  start_ok;
    logic                  bypass;

    assign wr_en     = (state_q == LOADING) && load_valid;
    assign wr_addr   = base_q + idx_q[ADDR_WIDTH-1:0];
    assign last_word = (idx_q == (len_q - 1'b1));
    assign start_ok  = load_start && (load_len != '0);
    assign bypass    = wr_en && (wr_addr == fibre_a_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = LOADING;
            LOADING: if (wr_en && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == LOADING);
    end

    always_comb begin
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        done_d    = wr_en && last_word;
        written_d = written_q;
        if (state_q == IDLE && start_ok) begin
            base_d = load_base;
            len_d  = load_len;
            idx_d  = '0;
        end else if (wr_en) begin
            idx_d = idx_q + 1'b1;
        end
        if (wr_en) written_d[wr_addr] = 1'b1;

        // Same-edge write to the read address is forwarded so the read sees the new word.
        s1_valid_d = fibre_a_read_en;
        s1_hit_d   = bypass || written_q[fibre_a_addr];
        s1_data_d  = bypass ? load_data : mem[fibre_a_addr];

        valid_d = s1_valid_q;
        data_d  = data_q;
        if (s1_valid_q) data_d = s1_hit_q ? s1_data_q : '0;
        err_d = err_q || (s1_valid_q && !s1_hit_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            written_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_data_q  <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            written_q  <= written_d;
            s1_valid_q <= s1_valid_d;
            s1_hit_q   <= s1_hit_d;
            s1_data_q  <= s1_data_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    // Storage is deliberately not reset; the written bits gate what reads may return.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= load_data;
    end

    assign fibre_a_valid = valid_q;
    assign fibre_a_data  = data_q;
    assign load_done     = done_q;
    assign rd_err        = err_q;

endmodule

// File: tb/tb_fibre_a_responder.sv
// Directed bench for fibre_a_responder: bursts, wrap, collisions, stale reads and async reset.
module tb_fibre_a_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        fibre_a_read_en;
    logic [7:0]  fibre_a_addr;
    logic [15:0] fibre_a_data;
    logic        fibre_a_valid;
    logic        load_start;
    logic [7:0]  load_base;
    logic [8:0]  load_len;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        rd_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] wdata [256];
    logic [15:0] exp34 [4];

    fibre_a_responder #(.TIMESTEPS(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .fibre_a_read_en(fibre_a_read_en), .fibre_a_addr(fibre_a_addr),
        .fibre_a_data(fibre_a_data), .fibre_a_valid(fibre_a_valid),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_burst(input logic [7:0] base, input int n);
        load_start = 1'b1;
        load_base  = base;
        load_len   = 9'(n);
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("ready_burst", 32'(load_ready), 32'h1);
            chk("done_early", 32'(load_done), 32'h0);
            load_valid = 1'b1;
            load_data  = wdata[i];
            @(negedge clk);
        end
        load_valid = 1'b0;
        chk("done_pulse", 32'(load_done), 32'h1);
        chk("ready_end", 32'(load_ready), 32'h0);
        @(negedge clk);
        chk("done_single", 32'(load_done), 32'h0);
    endtask

    task automatic read_one(input logic [7:0] a, input logic [15:0] ed, input logic ee, input string tag);
        fibre_a_read_en = 1'b1;
        fibre_a_addr    = a;
        @(negedge clk);
        fibre_a_read_en = 1'b0;
        chk({tag, "_lat"}, 32'(fibre_a_valid), 32'h0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(fibre_a_valid), 32'h1);
        chk({tag, "_data"}, 32'(fibre_a_data), 32'(ed));
        chk({tag, "_err"}, 32'(rd_err), 32'(ee));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        fibre_a_read_en = 1'b0; fibre_a_addr = '0;
        load_start = 1'b0; load_base = '0; load_len = '0;
        load_valid = 1'b0; load_data = '0;
        #2;
        chk("rst_valid", 32'(fibre_a_valid), 32'h0);
        chk("rst_data", 32'(fibre_a_data), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h0);
        chk("rst_done", 32'(load_done), 32'h0);
        chk("rst_err", 32'(rd_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // basic burst and back-to-back reads
        exp34[0] = 16'h0001; exp34[1] = 16'h0002; exp34[2] = 16'h0004; exp34[3] = 16'h0008;
        for (int i = 0; i < 4; i++) wdata[i] = exp34[i];
        load_burst(8'h10, 4);
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                chk("b2b_valid", 32'(fibre_a_valid), 32'h1);
                chk("b2b_data", 32'(fibre_a_data), 32'(exp34[i-2]));
            end else begin
                chk("b2b_idle", 32'(fibre_a_valid), 32'h0);
            end
            fibre_a_read_en = (i < 4);
            fibre_a_addr    = 8'(8'h10 + i);
            @(negedge clk);
        end
        chk("b2b_tail_valid", 32'(fibre_a_valid), 32'h0);
        chk("b2b_hold_data", 32'(fibre_a_data), 32'h0008);
        chk("b2b_err", 32'(rd_err), 32'h0);

        // wrapping burst
        wdata[0] = 16'h0A0A; wdata[1] = 16'h0B0B; wdata[2] = 16'h0C0C;
        load_burst(8'hFE, 3);
        read_one(8'hFE, 16'h0A0A, 1'b0, "wrap_fe");
        read_one(8'hFF, 16'h0B0B, 1'b0, "wrap_ff");
        read_one(8'h00, 16'h0C0C, 1'b0, "wrap_00");

        // read one edge before a write sees old data; same-edge read sees new data
        wdata[0] = 16'h5555;
        load_burst(8'h20, 1);
        load_start = 1'b1; load_base = 8'h20; load_len = 9'd1;
        fibre_a_read_en = 1'b1; fibre_a_addr = 8'h20;
        @(negedge clk);
        load_start = 1'b0;
        chk("col_ready", 32'(load_ready), 32'h1);
        load_valid = 1'b1; load_data = 16'hAAAA;
        @(negedge clk);
        load_valid = 1'b0; fibre_a_read_en = 1'b0;
        chk("col_old_valid", 32'(fibre_a_valid), 32'h1);
        chk("col_old_data", 32'(fibre_a_data), 32'h5555);
        chk("col_done", 32'(load_done), 32'h1);
        @(negedge clk);
        chk("col_new_valid", 32'(fibre_a_valid), 32'h1);
        chk("col_new_data", 32'(fibre_a_data), 32'hAAAA);
        chk("col_err", 32'(rd_err), 32'h0);

        // zero-length start and restart during a burst are ignored
        load_start = 1'b1; load_base = 8'h30; load_len = 9'd0;
        load_valid = 1'b1; load_data = 16'h1234;
        @(negedge clk);
        chk("len0_ready", 32'(load_ready), 32'h0);
        load_start = 1'b0;
        @(negedge clk);
        chk("len0_ready2", 32'(load_ready), 32'h0);
        chk("len0_done", 32'(load_done), 32'h0);
        load_valid = 1'b0;
        load_start = 1'b1; load_base = 8'h50; load_len = 9'd2;
        @(negedge clk);
        load_start = 1'b1; load_base = 8'h60; load_len = 9'd1;
        load_valid = 1'b1; load_data = 16'h5050;
        @(negedge clk);
        load_start = 1'b0; load_data = 16'h5151;
        chk("restart_ready", 32'(load_ready), 32'h1);
        chk("restart_done", 32'(load_done), 32'h0);
        @(negedge clk);
        load_valid = 1'b0;
        chk("restart_done_end", 32'(load_done), 32'h1);
        chk("restart_ready_end", 32'(load_ready), 32'h0);
        @(negedge clk);
        chk("restart_done_once", 32'(load_done), 32'h0);
        read_one(8'h50, 16'h5050, 1'b0, "restart_50");
        read_one(8'h51, 16'h5151, 1'b0, "restart_51");

        // unwritten reads set sticky rd_err
        read_one(8'h40, 16'h0000, 1'b1, "stale_40");
        read_one(8'h10, 16'h0001, 1'b1, "sticky_10");
        read_one(8'h30, 16'h0000, 1'b1, "stale_30");
        read_one(8'h60, 16'h0000, 1'b1, "stale_60");

        // async reset mid-burst with reads in flight
        for (int i = 0; i < 8; i++) wdata[i] = 16'h7000 + 16'(i);
        load_start = 1'b1; load_base = 8'h70; load_len = 9'd8;
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b1; load_data = wdata[0];
        fibre_a_read_en = 1'b1; fibre_a_addr = 8'h10;
        @(negedge clk);
        load_data = wdata[1];
        fibre_a_addr = 8'h11;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(fibre_a_valid), 32'h0);
        chk("arst_data", 32'(fibre_a_data), 32'h0);
        chk("arst_ready", 32'(load_ready), 32'h0);
        chk("arst_done", 32'(load_done), 32'h0);
        chk("arst_err", 32'(rd_err), 32'h0);
        fibre_a_read_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fibre_a_read_en = 1'b1; fibre_a_addr = 8'h10;
        @(negedge clk);
        fibre_a_read_en = 1'b0;
        chk("post_rst_stale", 32'(fibre_a_valid), 32'h0);
        chk("post_rst_ready", 32'(load_ready), 32'h0);
        @(negedge clk);
        chk("post_rst_valid", 32'(fibre_a_valid), 32'h1);
        chk("post_rst_data", 32'(fibre_a_data), 32'h0);
        chk("post_rst_err", 32'(rd_err), 32'h1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(fibre_a_valid), 32'h0);
            chk("post_rst_noload", 32'(load_ready), 32'h0);
            chk("post_rst_nodone", 32'(load_done), 32'h0);
        end
        load_valid = 1'b0;
        read_one(8'h70, 16'h0000, 1'b1, "post_rst_70");

        // full-depth burst writes every word once
        for (int i = 0; i < 256; i++) wdata[i] = {8'hC3, 8'(8'h80 + i)};
        load_burst(8'h80, 256);
        read_one(8'h80, 16'hC380, 1'b1, "full_80");
        read_one(8'h7F, 16'hC37F, 1'b1, "full_7f");
        read_one(8'h00, 16'hC300, 1'b1, "full_00");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
